// File: rtl/serial_addr_rx_pkg.sv
// Shared types and sizes for the serial address/data receiver.
// Holds the FSM state encoding, the fixed address width and the default data width.
package serial_addr_rx_pkg;

    localparam int ADDR_BITS = 8;
    localparam int DW_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/serial_shift_cnt.sv
// MSB-first shift register with a qualified-bit counter; last_o flags the W-th bit.
// word_o already includes the bit being shifted on this edge, so it can be latched directly.
module serial_shift_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] word_o,
    output logic         last_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    cat;

    always_comb begin
        cat    = {sh_q, bit_i};
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        last_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            sh_d = cat[W-1:0];
            if (cnt_q == CW'(W - 1)) begin
                cnt_d  = '0;
                last_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign word_o = cat[W-1:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_addr_rx.sv
// Serial frame receiver: 8 address bits then DW data bits, committed as WR or DROP.
// A frame cut short by CS_N rising yields FRAME_ERR and leaves D untouched.
module serial_addr_rx
    import serial_addr_rx_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 CS_N,
    input  logic                 SEN,
    input  logic                 SDI,
    input  logic                 ADR_MATCH,
    output logic [ADDR_BITS-1:0] A,
    output logic [DW-1:0]        D,
    output logic                 WR,
    output logic                 DROP,
    output logic                 FRAME_ERR,
    output logic                 BUSY
);

    state_t               state_q;
    logic [ADDR_BITS-1:0] a_q;
    logic [DW-1:0]        d_q;
    logic                 wr_q, drop_q, ferr_q, busy_q;

    logic                 qual, adr_en, dat_en, abort;
    logic [ADDR_BITS-1:0] adr_word;
    logic [DW-1:0]        dat_word;
    logic                 adr_last, dat_last;

    // The bit on the IDLE->ADDR edge is already address bit 7.
    assign qual   = !CS_N && SEN;
    assign adr_en = qual && (state_q == ST_IDLE || state_q == ST_ADDR);
    assign dat_en = qual && (state_q == ST_DATA);
    assign abort  = CS_N && (state_q == ST_ADDR || state_q == ST_DATA);

    serial_shift_cnt #(.W(ADDR_BITS)) u_adr (
        .clk_i   (CLK),
        .rst_n_i (RESET_N),
        .clr_i   (abort),
        .en_i    (adr_en),
        .bit_i   (SDI),
        .word_o  (adr_word),
        .last_o  (adr_last)
    );

    serial_shift_cnt #(.W(DW)) u_dat (
        .clk_i   (CLK),
        .rst_n_i (RESET_N),
        .clr_i   (abort),
        .en_i    (dat_en),
        .bit_i   (SDI),
        .word_o  (dat_word),
        .last_o  (dat_last)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            d_q     <= '0;
            wr_q    <= 1'b0;
            drop_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            drop_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!CS_N) begin
                        state_q <= ST_ADDR;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (CS_N) begin
                        state_q <= ST_IDLE;
                        ferr_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (adr_last) begin
                        a_q     <= adr_word;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (CS_N) begin
                        state_q <= ST_IDLE;
                        ferr_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (dat_last) begin
                        d_q     <= dat_word;
                        state_q <= ST_DONE;
                        wr_q    <= ADR_MATCH;
                        drop_q  <= !ADR_MATCH;
                    end
                end
                ST_DONE: begin
                    if (CS_N) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A         = a_q;
    assign D         = d_q;
    assign WR        = wr_q;
    assign DROP      = drop_q;
    assign FRAME_ERR = ferr_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_serial_addr_rx.sv
// Directed bench for serial_addr_rx with an address decoder matching 0xF8..0xFF.
module tb_serial_addr_rx;

    logic       CLK = 1'b0;
    logic       RESET_N, CS_N, SEN, SDI, ADR_MATCH;
    logic [7:0] A;
    logic [7:0] D;
    logic       WR, DROP, FRAME_ERR, BUSY;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt, drop_cnt, ferr_cnt;
    logic [7:0] wr_a[$];
    logic [7:0] wr_d[$];

    always #5 CLK = ~CLK;

    assign ADR_MATCH = (A[7:3] == 5'b11111);

    serial_addr_rx #(.DW(8)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .CS_N      (CS_N),
        .SEN       (SEN),
        .SDI       (SDI),
        .ADR_MATCH (ADR_MATCH),
        .A         (A),
        .D         (D),
        .WR        (WR),
        .DROP      (DROP),
        .FRAME_ERR (FRAME_ERR),
        .BUSY      (BUSY)
    );

    function automatic logic [7:0] qget(input logic [7:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 8'hxx;
    endfunction

    // One clock: apply inputs, step past the rising edge, log strobes.
    task automatic cyc(input logic cs, input logic sen, input logic sdi);
        CS_N = cs; SEN = sen; SDI = sdi;
        @(posedge CLK); #1;
        if (WR) begin wr_cnt++; wr_a.push_back(A); wr_d.push_back(D); end
        if (DROP) drop_cnt++;
        if (FRAME_ERR) ferr_cnt++;
    endtask

    task automatic clr_mon();
        wr_cnt = 0; drop_cnt = 0; ferr_cnt = 0;
        wr_a.delete(); wr_d.delete();
    endtask

    task automatic send_frame(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) cyc(1'b0, 1'b1, v[i]);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; CS_N = 1'b1; SEN = 1'b0; SDI = 1'b0;
        #1;
        n_checks++; if (A !== 8'h00) begin n_fail++; $display("FAIL reset_A got=%h exp=%h", A, 8'h00); end
        n_checks++; if (D !== 8'h00) begin n_fail++; $display("FAIL reset_D got=%h exp=%h", D, 8'h00); end
        n_checks++; if (WR !== 1'b0) begin n_fail++; $display("FAIL reset_WR got=%b exp=0", WR); end
        n_checks++; if (DROP !== 1'b0) begin n_fail++; $display("FAIL reset_DROP got=%b exp=0", DROP); end
        n_checks++; if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_FERR got=%b exp=0", FRAME_ERR); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_BUSY got=%b exp=0", BUSY); end
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        clr_mon();
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_idle_BUSY got=%b exp=0", BUSY); end
    endtask

    task automatic test_write();
        logic [15:0] v;
        v = 16'hFDA5;
        clr_mon();
        for (int i = 15; i >= 8; i--) cyc(1'b0, 1'b1, v[i]);
        n_checks++; if (A !== 8'hFD) begin n_fail++; $display("FAIL write_A_after8 got=%h exp=%h", A, 8'hFD); end
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL write_BUSY got=%b exp=1", BUSY); end
        for (int i = 7; i >= 1; i--) cyc(1'b0, 1'b1, v[i]);
        n_checks++; if (WR !== 1'b0) begin n_fail++; $display("FAIL write_WR_early got=%b exp=0", WR); end
        cyc(1'b0, 1'b1, v[0]);
        n_checks++; if (WR !== 1'b1) begin n_fail++; $display("FAIL write_WR got=%b exp=1", WR); end
        n_checks++; if (DROP !== 1'b0) begin n_fail++; $display("FAIL write_DROP got=%b exp=0", DROP); end
        n_checks++; if (D !== 8'hA5) begin n_fail++; $display("FAIL write_D got=%h exp=%h", D, 8'hA5); end
        cyc(1'b0, 1'b1, 1'b0);
        n_checks++; if (WR !== 1'b0) begin n_fail++; $display("FAIL write_WR_one_cycle got=%b exp=0", WR); end
        n_checks++; if (D !== 8'hA5) begin n_fail++; $display("FAIL write_D_done_hold got=%h exp=%h", D, 8'hA5); end
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL write_BUSY_done got=%b exp=1", BUSY); end
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL write_BUSY_end got=%b exp=0", BUSY); end
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL write_wr_count got=%0d exp=1", wr_cnt); end
    endtask

    task automatic test_drop();
        clr_mon();
        send_frame(16'h7D3C);
        n_checks++; if (DROP !== 1'b1) begin n_fail++; $display("FAIL drop_DROP got=%b exp=1", DROP); end
        n_checks++; if (WR !== 1'b0) begin n_fail++; $display("FAIL drop_WR got=%b exp=0", WR); end
        n_checks++; if (A !== 8'h7D) begin n_fail++; $display("FAIL drop_A got=%h exp=%h", A, 8'h7D); end
        n_checks++; if (D !== 8'h3C) begin n_fail++; $display("FAIL drop_D got=%h exp=%h", D, 8'h3C); end
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++; if (DROP !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle got=%b exp=0", DROP); end
        n_checks++; if (drop_cnt !== 1 || wr_cnt !== 0) begin n_fail++; $display("FAIL drop_counts got drop=%0d wr=%0d exp drop=1 wr=0", drop_cnt, wr_cnt); end
    endtask

    task automatic test_abort();
        logic [15:0] v;
        v = 16'hF8FF;
        clr_mon();
        for (int i = 15; i >= 6; i--) cyc(1'b0, 1'b1, v[i]);
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++; if (FRAME_ERR !== 1'b1) begin n_fail++; $display("FAIL abort_FERR got=%b exp=1", FRAME_ERR); end
        n_checks++; if (A !== 8'hF8) begin n_fail++; $display("FAIL abort_A got=%h exp=%h", A, 8'hF8); end
        n_checks++; if (D !== 8'h3C) begin n_fail++; $display("FAIL abort_D got=%h exp=%h", D, 8'h3C); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_BUSY got=%b exp=0", BUSY); end
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++; if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL abort_FERR_one_cycle got=%b exp=0", FRAME_ERR); end
        n_checks++; if (ferr_cnt !== 1 || wr_cnt !== 0 || drop_cnt !== 0) begin
            n_fail++; $display("FAIL abort_counts got ferr=%0d wr=%0d drop=%0d exp 1/0/0", ferr_cnt, wr_cnt, drop_cnt);
        end
    endtask

    task automatic test_stall();
        logic [15:0] v;
        int k, wr_at;
        v = 16'hFF01; k = 0; wr_at = -1;
        clr_mon();
        for (int i = 15; i >= 0; i--) begin
            cyc(1'b0, 1'b1, v[i]);
            k++;
            if (WR && wr_at < 0) wr_at = k;
            if (k == 15) begin
                n_checks++; if (A !== 8'hFF) begin n_fail++; $display("FAIL stall_A_after8 got=%h exp=%h", A, 8'hFF); end
            end
            cyc(1'b0, 1'b0, ~v[i]);
            k++;
            if (WR && wr_at < 0) wr_at = k;
            if (k == 14) begin
                n_checks++; if (A !== 8'hF8) begin n_fail++; $display("FAIL stall_A_hold got=%h exp=%h", A, 8'hF8); end
            end
        end
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++; if (wr_at !== 31) begin n_fail++; $display("FAIL stall_wr_cycle got=%0d exp=31", wr_at); end
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL stall_wr_count got=%0d exp=1", wr_cnt); end
        n_checks++; if (qget(wr_d, 0) !== 8'h01) begin n_fail++; $display("FAIL stall_D got=%h exp=%h", qget(wr_d, 0), 8'h01); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        v = 16'hF9AA;
        clr_mon();
        for (int i = 15; i >= 5; i--) cyc(1'b0, 1'b1, v[i]);
        RESET_N = 1'b0;
        #1;
        n_checks++; if (A !== 8'h00 || D !== 8'h00) begin n_fail++; $display("FAIL rstmid_AD got A=%h D=%h exp 00/00", A, D); end
        n_checks++; if (BUSY !== 1'b0 || WR !== 1'b0) begin n_fail++; $display("FAIL rstmid_BUSY_WR got %b/%b exp 0/0", BUSY, WR); end
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        CS_N = 1'b1;
        RESET_N = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        n_checks++; if (wr_cnt + drop_cnt + ferr_cnt !== 0) begin
            n_fail++; $display("FAIL rstmid_no_strobe got wr=%0d drop=%0d ferr=%0d exp 0", wr_cnt, drop_cnt, ferr_cnt);
        end
        n_checks++; if (BUSY !== 1'b0 || A !== 8'h00) begin n_fail++; $display("FAIL rstmid_idle got BUSY=%b A=%h exp 0/00", BUSY, A); end
        send_frame(16'hF911);
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL rstmid_wr_count got=%0d exp=1", wr_cnt); end
        n_checks++; if (qget(wr_a, 0) !== 8'hF9 || qget(wr_d, 0) !== 8'h11) begin
            n_fail++; $display("FAIL rstmid_pair got A=%h D=%h exp F9/11", qget(wr_a, 0), qget(wr_d, 0));
        end
    endtask

    task automatic test_back_to_back();
        clr_mon();
        send_frame(16'hF811);
        cyc(1'b1, 1'b0, 1'b0);
        send_frame(16'hFF22);
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL b2b_wr_count got=%0d exp=2", wr_cnt); end
        n_checks++; if (drop_cnt !== 0 || ferr_cnt !== 0) begin n_fail++; $display("FAIL b2b_other got drop=%0d ferr=%0d exp 0/0", drop_cnt, ferr_cnt); end
        n_checks++; if (qget(wr_a, 0) !== 8'hF8 || qget(wr_d, 0) !== 8'h11) begin
            n_fail++; $display("FAIL b2b_pair0 got A=%h D=%h exp F8/11", qget(wr_a, 0), qget(wr_d, 0));
        end
        n_checks++; if (qget(wr_a, 1) !== 8'hFF || qget(wr_d, 1) !== 8'h22) begin
            n_fail++; $display("FAIL b2b_pair1 got A=%h D=%h exp FF/22", qget(wr_a, 1), qget(wr_d, 1));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_drop();
        test_abort();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addr_rx.md
SERIAL_ADDR_RX -- requirements
Module: serial_addr_rx

Interface
REQ-001 Parameter: DW, 8, data-field width in bits; legal values 1..16.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RESET_N  input  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low.
REQ-004 Port: CS_N  input  1  frame select, active-low; a frame spans one continuous low period.
REQ-005 Port: SEN  input  1  bit-enable; SDI is sampled only on edges where CS_N=0 and SEN=1.
REQ-006 Port: SDI  input  1  serial data, MSB first: 8 address bits, then DW data bits.
REQ-007 Port: ADR_MATCH  input  1  combinational match from the downstream 8-bit address decoder, driven from A.
REQ-008 Port: A  output  8  latched address; feeds the downstream decoder.
REQ-009 Port: D  output  DW  latched data field.
REQ-010 Port: WR  output  1  one-cycle commit strobe for a matched frame.
REQ-011 Port: DROP  output  1  one-cycle strobe for a complete frame with ADR_MATCH=0.
REQ-012 Port: FRAME_ERR  output  1  one-cycle strobe when CS_N rises before a frame completes.
REQ-013 Port: BUSY  output  1  high in states ADDR, DATA and DONE.

Function
REQ-014 FSM states: IDLE, ADDR, DATA, DONE.
REQ-015 IDLE->ADDR on any edge with CS_N=0; a qualified bit on that same edge counts as address bit 7.
REQ-016 ADDR: shift qualified bits into an 8-bit shift register; 3-bit counter counts qualified bits; after the 8th, load A with all 8 bits on that edge and go to DATA.
REQ-017 A changes only at the end of an address phase and holds its value otherwise, including through an abort.
REQ-018 DATA: shift DW qualified bits; after the DW-th, load D and go to DONE.
REQ-019 On the edge entering DONE, WR=1 if ADR_MATCH=1, else DROP=1; exactly one of WR and DROP pulses for one cycle; ADR_MATCH is sampled on that edge.
REQ-020 DONE: ignore further SDI bits; go to IDLE on the first edge with CS_N=1.
REQ-021 CS_N=1 in ADDR or DATA: go to IDLE, pulse FRAME_ERR for one cycle, no WR or DROP, D unchanged, counter cleared.
REQ-022 SEN=0 stalls shifting and counting without limit; no timeout.
REQ-023 Minimum gap between frames is one CS_N-high cycle; back-to-back frames lose no bits.
REQ-024 WR, DROP and FRAME_ERR are registered outputs and are never high at the same time.

Reset
REQ-025 RESET_N=0 forces, asynchronously: state IDLE, A=8'h00, D=0, counter=0, shift register=0, WR=DROP=FRAME_ERR=BUSY=0.
REQ-026 Reset asserted mid-frame discards the partial frame and generates no strobe, including after release.
REQ-027 After RESET_N releases, the first frame starts only on a fresh edge with CS_N=0.

Structure
REQ-028 Shared package holds the state enum, ADDR_BITS=8 and the default DW.
REQ-029 One sub-module, serial_shift_cnt: shift register plus bit counter, instanced for the address field and for the data field.

Verification
REQ-030 CS_N low, SEN=1, bits 0xFD then 0xA5 -> A=0xFD after bit 8; WR high one cycle with D=0xA5 on the edge after bit 16; BUSY low one cycle after CS_N rises.
REQ-031 Frame 0x7D/0x3C with decoder connected -> ADR_MATCH=0, DROP pulses once, WR stays 0, D=0x3C.
REQ-032 CS_N rises after 10 bits of 0xF8/0xFF -> FRAME_ERR for one cycle, A=0xF8, D keeps its previous value, no WR.
REQ-033 SEN toggled 1/0 every cycle through frame 0xFF/0x01 -> result identical to REQ-030 timing, stretched by 2x.
REQ-034 RESET_N pulsed low during data bit 4 -> all outputs at reset values; no strobe on release; next full frame 0xF9/0x11 gives a normal WR.
REQ-035 Two frames 0xF8/0x11 and 0xFF/0x22 separated by one CS_N-high cycle -> two WR pulses carrying the correct A/D pairs.
